// File: rtl/cc_miss_request_unit_pkg.sv
// Shared types and AXI constants for the cache miss-request path.
package cc_miss_request_unit_pkg;

  typedef enum logic [0:0] {
    S_IDLE,
    S_AR_SEND
  } miss_req_state_t;

  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam int         LINE_BEATS     = 8;
  localparam int         CNT_W          = 3;

endpackage

// File: rtl/cc_miss_request_unit_counter.sv
// Outstanding line-fill counter: up on accept, down on the last R beat,
// with a sticky error when a last beat arrives while nothing is outstanding.
module cc_outstanding_counter
  import cc_miss_request_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case ({inc_i, dec_i})
      2'b10: if (count_q != '1) count_d = count_q + 1'b1;
      2'b01: begin
        if (count_q == '0) err_d = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/cc_miss_request_unit.sv
// Accepts one read miss at a time, pushes its address to the miss FIFO and
// issues a wrapping critical-word-first AXI read burst for the line.
module cc_miss_request_unit
  import cc_miss_request_unit_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_LEN       = LINE_BEATS,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_ID          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] miss_req_addr_i,
  output logic                  miss_req_ready_o,
  input  logic                  miss_addr_fifo_full_i,
  output logic                  miss_addr_fifo_wren_o,
  output logic [ADDR_WIDTH-1:0] miss_addr_fifo_wdata_o,
  output logic [3:0]            mem_arid_o,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic [3:0]            mem_arlen_o,
  output logic [2:0]            mem_arsize_o,
  output logic [1:0]            mem_arburst_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rready_i,
  input  logic                  mem_rlast_i,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  miss_req_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  fill_done;

  // Gating with rst_n keeps ready low during reset even though the FIFO-full
  // input may still be deasserted by an upstream block that is not in reset.
  assign miss_req_ready_o = rst_n && (state_q == S_IDLE) && !miss_addr_fifo_full_i
                            && (outstanding < MAX_OUT);
  assign accept    = miss_req_valid_i && miss_req_ready_o;
  assign fill_done = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  // The FIFO push happens in the accept cycle, one cycle ahead of ARVALID.
  assign miss_addr_fifo_wren_o  = accept;
  assign miss_addr_fifo_wdata_o = miss_req_addr_i;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_AR_SEND;
          araddr_d = {miss_req_addr_i[ADDR_WIDTH-1:3], 3'b000};
        end
      end
      S_AR_SEND: begin
        if (mem_arready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
    end
  end

  cc_outstanding_counter u_outstanding (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (accept),
    .dec_i   (fill_done),
    .count_o (outstanding),
    .err_o   (err_o)
  );

  assign mem_arvalid_o = (state_q == S_AR_SEND);
  assign mem_araddr_o  = araddr_q;
  assign mem_arid_o    = 4'(AXI_ID);
  assign mem_arlen_o   = 4'(BURST_LEN - 1);
  assign mem_arsize_o  = AXI_SIZE_8B;
  assign mem_arburst_o = AXI_BURST_WRAP;
  assign outstanding_o = outstanding;

endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Scenario tasks plus a cycle-level behavioural model of the miss path checked every cycle.
module tb_cc_miss_request_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic        ready;
  logic        full = 1'b0;
  logic        wren;
  logic [31:0] wdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic [2:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: number of unfinished fills, sticky error, and the AR
  // request (if any) that is waiting for memory to take it.
  int          m_out = 0;
  bit          m_err = 1'b0;
  bit          m_busy = 1'b0;
  logic [31:0] m_araddr = '0;

  cc_miss_request_unit dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_valid_i       (valid),
    .miss_req_addr_i        (addr),
    .miss_req_ready_o       (ready),
    .miss_addr_fifo_full_i  (full),
    .miss_addr_fifo_wren_o  (wren),
    .miss_addr_fifo_wdata_o (wdata),
    .mem_arid_o             (arid),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arvalid_o          (arvalid),
    .mem_arready_i          (arready),
    .mem_rvalid_i           (rvalid),
    .mem_rready_i           (rready),
    .mem_rlast_i            (rlast),
    .outstanding_o          (outstanding),
    .err_o                  (err)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return rst_n && !m_busy && !full && (m_out < 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = 0; m_err = 1'b0; m_busy = 1'b0; m_araddr = '0;
    end else begin
      bit acc, fill;
      acc  = valid && model_ready();
      fill = rvalid && rready && rlast;
      if (m_busy && arready) m_busy = 1'b0;
      if (acc) begin
        m_busy   = 1'b1;
        m_araddr = addr & 32'hFFFF_FFF8;
      end
      if (acc && !fill) m_out = m_out + 1;
      else if (fill && !acc) begin
        if (m_out == 0) m_err = 1'b1;
        else            m_out = m_out - 1;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = model_ready();
    checks++;
    if (ready !== exp_ready) begin
      errors++; $display("FAIL mon_ready got %b exp %b at %0t", ready, exp_ready, $time);
    end
    checks++;
    if (wren !== (valid && exp_ready)) begin
      errors++; $display("FAIL mon_wren got %b exp %b at %0t", wren, valid && exp_ready, $time);
    end
    if (valid && exp_ready) begin
      checks++;
      if (wdata !== addr) begin
        errors++; $display("FAIL mon_wdata got %h exp %h at %0t", wdata, addr, $time);
      end
    end
    checks++;
    if (arvalid !== m_busy) begin
      errors++; $display("FAIL mon_arvalid got %b exp %b at %0t", arvalid, m_busy, $time);
    end
    if (m_busy) begin
      checks++;
      if (araddr !== m_araddr) begin
        errors++; $display("FAIL mon_araddr got %h exp %h at %0t", araddr, m_araddr, $time);
      end
    end
    checks++;
    if (outstanding !== 3'(m_out) || err !== m_err) begin
      errors++;
      $display("FAIL mon_count got out=%0d err=%b exp out=%0d err=%b at %0t",
               outstanding, err, m_out, m_err, $time);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; addr = '0; full = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1; full = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || wren !== 1'b0 || arvalid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got ready=%b wren=%b arvalid=%b exp 0 0 0", ready, wren, arvalid);
    end
    checks++;
    if (araddr !== 32'h0 || outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_state got araddr=%h out=%0d err=%b exp 0 0 0", araddr, outstanding, err);
    end
    checks++;
    if (arid !== 4'd0 || arlen !== 4'd7 || arsize !== 3'b011 || arburst !== 2'b10) begin
      errors++; $display("FAIL reset_static got id=%h len=%h size=%b burst=%b exp 0 7 011 10", arid, arlen, arsize, arburst);
    end
    do_reset();
  endtask

  task automatic test_single_miss();
    valid = 1'b1; addr = 32'h0001_2348;
    #1;
    checks++;
    if (ready !== 1'b1 || wren !== 1'b1 || wdata !== 32'h0001_2348) begin
      errors++; $display("FAIL single_push got ready=%b wren=%b wdata=%h exp 1 1 00012348", ready, wren, wdata);
    end
    next();
    valid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0001_2348 || arlen !== 4'd7 || arburst !== 2'b10) begin
      errors++; $display("FAIL single_ar got v=%b a=%h len=%h burst=%b exp 1 00012348 7 10", arvalid, araddr, arlen, arburst);
    end
    next();
    arready = 1'b1;
    next();
    arready = 1'b0;
    checks++;
    if (arvalid !== 1'b0 || outstanding !== 3'd1) begin
      errors++; $display("FAIL single_after_ar got arvalid=%b out=%0d exp 0 1", arvalid, outstanding);
    end
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rready = 1'b1; rlast = (i == 7);
      next();
      if (i < 7) begin
        checks++;
        if (outstanding !== 3'd1) begin
          errors++; $display("FAIL single_beat%0d got out=%0d exp 1", i, outstanding);
        end
      end
    end
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL single_done got out=%0d err=%b exp 0 0", outstanding, err);
    end
    do_reset();
  endtask

  task automatic test_ar_stall();
    int pushes = 0;
    logic [31:0] a;
    a = $urandom;
    valid = 1'b1; addr = a;
    #1;
    if (wren) pushes++;
    next();
    for (int i = 0; i < 5; i++) begin
      addr = $urandom;
      #1;
      if (wren) pushes++;
      checks++;
      if (arvalid !== 1'b1 || araddr !== {a[31:3], 3'b000} || ready !== 1'b0) begin
        errors++; $display("FAIL stall_cyc%0d got v=%b a=%h rdy=%b exp 1 %h 0", i, arvalid, araddr, ready, {a[31:3], 3'b000});
      end
      next();
    end
    valid = 1'b0; arready = 1'b1;
    next();
    arready = 1'b0;
    checks++;
    if (pushes !== 1 || arvalid !== 1'b0) begin
      errors++; $display("FAIL stall_end got pushes=%0d arvalid=%b exp 1 0", pushes, arvalid);
    end
    do_reset();
  endtask

  task automatic test_throttle();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; addr = $urandom; arready = 1'b1;
      next();
      valid = 1'b0;
      next();
    end
    arready = 1'b0; valid = 1'b1; addr = $urandom;
    #1;
    checks++;
    if (outstanding !== 3'd4 || ready !== 1'b0 || wren !== 1'b0) begin
      errors++; $display("FAIL throttle_full got out=%0d ready=%b wren=%b exp 4 0 0", outstanding, ready, wren);
    end
    next();
    valid = 1'b0; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    next();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd3 || ready !== 1'b1) begin
      errors++; $display("FAIL throttle_reopen got out=%0d ready=%b exp 3 1", outstanding, ready);
    end
    do_reset();
  endtask

  task automatic test_fifo_full();
    full = 1'b1; valid = 1'b1; addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ready !== 1'b0 || wren !== 1'b0 || arvalid !== 1'b0) begin
        errors++; $display("FAIL full_block%0d got ready=%b wren=%b arvalid=%b exp 0 0 0", i, ready, wren, arvalid);
      end
      next();
    end
    full = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || wren !== 1'b1 || wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL full_release got ready=%b wren=%b wdata=%h exp 1 1 deadbeef", ready, wren, wdata);
    end
    next();
    valid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'hDEAD_BEE8 || outstanding !== 3'd1) begin
      errors++; $display("FAIL full_ar got v=%b a=%h out=%0d exp 1 deadbee8 1", arvalid, araddr, outstanding);
    end
    do_reset();
  endtask

  task automatic test_same_cycle();
    arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; addr = $urandom;
      next();
      valid = 1'b0;
      next();
    end
    arready = 1'b0; valid = 1'b1; addr = $urandom;
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    next();
    valid = 1'b0; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++;
    if (outstanding !== 3'd2 || err !== 1'b0 || arvalid !== 1'b1) begin
      errors++; $display("FAIL same_cycle got out=%0d err=%b arvalid=%b exp 2 0 1", outstanding, err, arvalid);
    end
    arready = 1'b1;
    next();
    arready = 1'b0;
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    next();
    next();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL same_drain got out=%0d err=%b exp 0 0", outstanding, err);
    end
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    next();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    checks++;
    if (outstanding !== 3'd0 || err !== 1'b1) begin
      errors++; $display("FAIL underflow got out=%0d err=%b exp 0 1", outstanding, err);
    end
    repeat (3) next();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b exp 1", err);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    valid = 1'b1; addr = 32'h0000_4000;
    next();
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    valid = 1'b1;
    #1;
    checks++;
    if (arvalid !== 1'b0 || ready !== 1'b0 || outstanding !== 3'd0 || wren !== 1'b0 || araddr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b rdy=%b out=%0d wren=%b a=%h exp 0 0 0 0 0",
               arvalid, ready, outstanding, wren, araddr);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      valid   = ($urandom_range(0, 99) < 60);
      addr    = $urandom;
      full    = ($urandom_range(0, 99) < 20);
      arready = ($urandom_range(0, 99) < 50);
      rvalid  = ($urandom_range(0, 99) < 50);
      rready  = ($urandom_range(0, 99) < 70);
      rlast   = ($urandom_range(0, 99) < 25);
      next();
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_ar_stall();
    test_throttle();
    test_fifo_full();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
